// File: rtl/pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_gen
//  Description : Burst-oriented test-pattern generator with a valid/ready
//                output handshake. Produces increment, decrement,
//                walking-one or constant word streams, either for a fixed
//                number of words or unbounded until an abort request.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     - data word width in bits (2..32)
//    LEN_W     - width of burst_len and of the internal word counter
//  Ports
//    clk       - in  : sole clock, rising edge
//    rst       - in  : asynchronous active-low reset
//    start     - in  : begin a burst (honoured only in IDLE)
//    stop      - in  : abort the running burst (honoured only in RUN)
//    mode      - in  : 00 inc, 01 dec, 10 walking-one, 11 constant
//    limit     - in  : wrap bound for inc/dec, value for constant
//    burst_len - in  : words per burst, 0 = unbounded
//    ready     - in  : downstream accept
//    data_out  - out : current word
//    valid     - out : data_out is offered (RUN only)
//    busy      - out : high in RUN
//    done      - out : one-cycle pulse after completion or abort
//    checksum  - out : running XOR of transferred words
//                      (present only when PATTERN_GEN_CHECKSUM_EN is defined)
//  Build option
//    PATTERN_GEN_CHECKSUM_EN - adds the checksum output and its register
// ============================================================================
module pattern_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             done
`ifdef PATTERN_GEN_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] checksum
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]       c_mode_inc  = 2'b00;
    localparam logic [1:0]       c_mode_dec  = 2'b01;
    localparam logic [1:0]       c_mode_walk = 2'b10;
    localparam logic [1:0]       c_mode_const = 2'b11;
    localparam logic [WIDTH-1:0] c_one_w     = WIDTH'(1);
    localparam logic [LEN_W-1:0] c_one_len   = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [1:0]         mode_q,  mode_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic [LEN_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   data_q,  data_d;
`ifdef PATTERN_GEN_CHECKSUM_EN
    logic [WIDTH-1:0]   chk_q,   chk_d;
`endif

    logic               xfer;
    logic               last_word;

    // ------------------------------------------------------------------------
    // Pattern functions
    // ------------------------------------------------------------------------
    // First word offered after start, taken from the live inputs since the
    // captured registers only load on the same edge.
    function automatic logic [WIDTH-1:0] first_word(
        input logic [1:0]       m,
        input logic [WIDTH-1:0] lim
    );
        logic [WIDTH-1:0] w;
        w = '0;
        case (m)
            c_mode_inc:   w = '0;
            c_mode_dec:   w = lim;
            c_mode_walk:  w = c_one_w;
            c_mode_const: w = lim;
            default:      w = '0;
        endcase
        return w;
    endfunction

    // Word following d. Increment and decrement re-enter the legal range
    // 0..lim from any out-of-range value, so lim = 0 yields a zero stream.
    function automatic logic [WIDTH-1:0] next_word(
        input logic [1:0]       m,
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] lim
    );
        logic [WIDTH-1:0] w;
        w = d;
        case (m)
            c_mode_inc:   w = (d >= lim) ? '0 : d + c_one_w;
            c_mode_dec:   w = ((d == '0) || (d > lim)) ? lim : d - c_one_w;
            c_mode_walk:  w = {d[WIDTH-2:0], d[WIDTH-1]};
            c_mode_const: w = lim;
            default:      w = d;
        endcase
        return w;
    endfunction

    // ------------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------------
    // valid is exactly "state is RUN", so a transfer is RUN && ready.
    assign xfer      = (state_q == S_RUN) && ready;
    // Counter holds the number of words already transferred in this burst.
    assign last_word = (len_q != '0) && (cnt_q == (len_q - c_one_len));

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        limit_d = limit_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef PATTERN_GEN_CHECKSUM_EN
        chk_d   = chk_q;
`endif

        case (state_q)
            S_IDLE: begin
                // start wins over a simultaneous stop; stop alone is ignored
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    limit_d = limit;
                    len_d   = burst_len;
                    cnt_d   = '0;
                    data_d  = first_word(mode, limit);
`ifdef PATTERN_GEN_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end

            S_RUN: begin
                if (xfer) begin
                    data_d = next_word(mode_q, data_q, limit_q);
                    // Unbounded bursts saturate rather than wrap the counter
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + c_one_len;
                    end
`ifdef PATTERN_GEN_CHECKSUM_EN
                    chk_d = chk_q ^ data_q;
`endif
                end
                // A transfer coinciding with stop still counts (handled above)
                if (stop || (xfer && last_word)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            limit_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef PATTERN_GEN_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            limit_q <= limit_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef PATTERN_GEN_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign data_out = data_q;
    assign valid    = (state_q == S_RUN);
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
`ifdef PATTERN_GEN_CHECKSUM_EN
    assign checksum = chk_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_gen
//  Description : Directed self-checking bench for pattern_gen (WIDTH=8).
//                Inputs change and outputs are sampled on the falling edge.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_pattern_gen;

    localparam int WIDTH = 8;
    localparam int LEN_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [WIDTH-1:0] limit;
    logic [LEN_W-1:0] burst_len;
    logic             ready;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             busy;
    logic             done;
`ifdef PATTERN_GEN_CHECKSUM_EN
    logic [WIDTH-1:0] checksum;
`endif

    int n_cmp;
    int n_fail;

    // {valid, busy, done, data_out}
    wire [WIDTH+2:0] obs   = {valid, busy, done, data_out};
    wire [2:0]       flags = {valid, busy, done};

    pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
`ifdef PATTERN_GEN_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .limit     (limit),
        .burst_len (burst_len),
        .ready     (ready),
        .data_out  (data_out),
        .valid     (valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue start at the current falling edge; returns on the next falling
    // edge with the first word visible. The configuration inputs are then
    // scrambled so that only the captured values can produce correct data.
    task automatic do_start(input logic [1:0] m, input logic [7:0] lim,
                            input logic [15:0] len);
        mode      = m;
        limit     = lim;
        burst_len = len;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        mode      = ~m;
        limit     = ~lim;
        burst_len = len + 16'd3;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00;
        limit = '0; burst_len = '0; ready = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs, 11'h000);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want %h", obs, 11'h000);
        end
    endtask

    // mode 00, limit 31, 40 words, ready always high
    task automatic test_increment;
        logic [7:0] e;
        ready = 1'b1;
        do_start(2'b00, 8'd31, 16'd40);
        for (int i = 0; i < 40; i++) begin
            e = 8'(i % 32);
            n_cmp++;
            if (obs !== {3'b110, e}) begin
                n_fail++;
                $display("FAIL inc_word[%0d]: got %h want %h", i, obs, {3'b110, e});
            end
            @(negedge clk);
        end
        n_cmp++;
        if (flags !== 3'b001) begin
            n_fail++;
            $display("FAIL inc_done: got %b want %b", flags, 3'b001);
        end
        @(negedge clk);
        n_cmp++;
        if (flags !== 3'b000) begin
            n_fail++;
            $display("FAIL inc_back_idle: got %b want %b", flags, 3'b000);
        end
    endtask

    // mode 01, limit 3, 6 words, ready alternating low/high
    task automatic test_decrement;
        logic [7:0] exp_dec [6];
        exp_dec = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3, 8'd2};
        ready = 1'b0;
        do_start(2'b01, 8'd3, 16'd6);
        for (int i = 0; i < 6; i++) begin
            ready = 1'b0;
            n_cmp++;
            if (obs !== {3'b110, exp_dec[i]}) begin
                n_fail++;
                $display("FAIL dec_word[%0d]: got %h want %h", i, obs, {3'b110, exp_dec[i]});
            end
            @(negedge clk);
            n_cmp++;
            if (obs !== {3'b110, exp_dec[i]}) begin
                n_fail++;
                $display("FAIL dec_hold[%0d]: got %h want %h", i, obs, {3'b110, exp_dec[i]});
            end
            ready = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (flags !== 3'b001) begin
            n_fail++;
            $display("FAIL dec_done: got %b want %b", flags, 3'b001);
        end
        @(negedge clk);
    endtask

    // mode 10, 10 words: 01,02,...,80,01,02
    task automatic test_walking;
        logic [7:0] e;
        ready = 1'b1;
        do_start(2'b10, 8'hFF, 16'd10);
        for (int i = 0; i < 10; i++) begin
            e = 8'h01 << (i % 8);
            n_cmp++;
            if (obs !== {3'b110, e}) begin
                n_fail++;
                $display("FAIL walk_word[%0d]: got %h want %h", i, obs, {3'b110, e});
            end
            @(negedge clk);
        end
        n_cmp++;
        if (flags !== 3'b001) begin
            n_fail++;
            $display("FAIL walk_done: got %b want %b", flags, 3'b001);
        end
        @(negedge clk);
    endtask

    // Constant mode and limit = 0 boundary in inc/dec
    task automatic test_constant;
        ready = 1'b1;
        do_start(2'b11, 8'h5A, 16'd3);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== {3'b110, 8'h5A}) begin
                n_fail++;
                $display("FAIL const_word[%0d]: got %h want %h", i, obs, {3'b110, 8'h5A});
            end
            @(negedge clk);
        end
        @(negedge clk);
        do_start(2'b01, 8'd0, 16'd3);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== {3'b110, 8'h00}) begin
                n_fail++;
                $display("FAIL dec_lim0[%0d]: got %h want %h", i, obs, {3'b110, 8'h00});
            end
            @(negedge clk);
        end
        @(negedge clk);
        do_start(2'b00, 8'd0, 16'd3);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== {3'b110, 8'h00}) begin
                n_fail++;
                $display("FAIL inc_lim0[%0d]: got %h want %h", i, obs, {3'b110, 8'h00});
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // Unbounded burst, stop together with the 5th transfer
    task automatic test_stop;
        ready = 1'b1;
        do_start(2'b00, 8'd255, 16'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) stop = 1'b1;
            n_cmp++;
            if (obs !== {3'b110, 8'(i)}) begin
                n_fail++;
                $display("FAIL stop_word[%0d]: got %h want %h", i, obs, {3'b110, 8'(i)});
            end
            @(negedge clk);
        end
        stop = 1'b0;
        // data advanced past the final (counted) transfer of word 4
        n_cmp++;
        if (obs !== {3'b001, 8'd5}) begin
            n_fail++;
            $display("FAIL stop_done: got %h want %h", obs, {3'b001, 8'd5});
        end
        @(negedge clk);
        n_cmp++;
        if (flags !== 3'b000) begin
            n_fail++;
            $display("FAIL stop_idle: got %b want %b", flags, 3'b000);
        end
    endtask

    // stop ignored in IDLE, start+stop in IDLE starts, start ignored in RUN
    task automatic test_priority;
        ready = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
        n_cmp++;
        if (flags !== 3'b000) begin
            n_fail++;
            $display("FAIL stop_in_idle: got %b want %b", flags, 3'b000);
        end
        stop = 1'b1;
        do_start(2'b00, 8'd15, 16'd4);
        stop = 1'b0;
        n_cmp++;
        if (obs !== {3'b110, 8'd0}) begin
            n_fail++;
            $display("FAIL start_beats_stop: got %h want %h", obs, {3'b110, 8'd0});
        end
        // restart attempt with walking-one mode while running
        mode  = 2'b10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (obs !== {3'b110, 8'd1}) begin
            n_fail++;
            $display("FAIL start_in_run: got %h want %h", obs, {3'b110, 8'd1});
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs !== {3'b110, 8'd3}) begin
            n_fail++;
            $display("FAIL prio_word3: got %h want %h", obs, {3'b110, 8'd3});
        end
        @(negedge clk);
        n_cmp++;
        if (flags !== 3'b001) begin
            n_fail++;
            $display("FAIL prio_done: got %b want %b", flags, 3'b001);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset during transfer 3 of 8, then a clean restart
    task automatic test_reset_mid;
        ready = 1'b1;
        do_start(2'b00, 8'd31, 16'd8);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs !== {3'b110, 8'd2}) begin
            n_fail++;
            $display("FAIL rstmid_pre: got %h want %h", obs, {3'b110, 8'd2});
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 11'h000) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h want %h", obs, 11'h000);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_nodone: got %b want %b", done, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs !== 11'h000) begin
            n_fail++;
            $display("FAIL rstmid_idle: got %h want %h", obs, 11'h000);
        end
        do_start(2'b00, 8'd31, 16'd8);
        n_cmp++;
        if (obs !== {3'b110, 8'd0}) begin
            n_fail++;
            $display("FAIL rstmid_restart: got %h want %h", obs, {3'b110, 8'd0});
        end
        for (int i = 0; i < 9; i++) @(negedge clk);
    endtask

`ifdef PATTERN_GEN_CHECKSUM_EN
    task automatic test_checksum;
        ready = 1'b1;
        do_start(2'b00, 8'd31, 16'd4);
        n_cmp++;
        if (checksum !== 8'h00) begin
            n_fail++;
            $display("FAIL chk_clear: got %h want %h", checksum, 8'h00);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (checksum !== 8'h01) begin
            n_fail++;
            $display("FAIL chk_mid: got %h want %h", checksum, 8'h01);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (checksum !== 8'h00) begin
            n_fail++;
            $display("FAIL chk_final: got %h want %h", checksum, 8'h00);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_increment();
        test_decrement();
        test_walking();
        test_constant();
        test_stop();
        test_priority();
        test_reset_mid();
`ifdef PATTERN_GEN_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
